// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
//   Shared definitions for the SDRAM request-port arbiter:
//     arb_state_t     - arbiter FSM states (IDLE, WAIT_ACK, WAIT_RD)
//     DEF_ADDR_W/DATA - default SDRAM word address / data widths
//     IDX_W/MAX_PORTS - port index width sized for the 8-port maximum
//     onehot_to_idx   - converts a one-hot grant vector to a port index
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RD  = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 24;
    localparam int DEF_DATA_W = 16;
    localparam int MAX_PORTS  = 8;
    localparam int IDX_W      = 3;

    // OR-ing indices is exact for a one-hot input; an all-zero input yields 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick
//   Combinational grant picker.
//   Ports:
//     req  [NPORTS]  request levels
//     ptr  [IDX_W]   index of the last served port
//     gnt  [NPORTS]  one-hot winner (0 when no request)
//     idx  [IDX_W]   index of the winner
//   Configuration macro SDRAM_ARB_FIXED_PRIO_EN: when defined, the lowest
//   requesting index wins and ptr is ignored; otherwise round-robin starting
//   at ptr+1 and wrapping modulo NPORTS.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = 4
) (
    input  logic [NPORTS-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NPORTS-1:0] gnt,
    output logic [IDX_W-1:0]  idx
);

    localparam logic [NPORTS-1:0] ONE = NPORTS'(1);

    always_comb begin
        logic [NPORTS-1:0] rot;
        gnt = '0;
        idx = '0;
        rot = '0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        // Scan high to low so the lowest requesting index is written last.
        for (int i = NPORTS - 1; i >= 0; i--) begin
            rot = req >> i;
            if (rot[0]) begin
                gnt = ONE << i;
                idx = IDX_W'(i);
            end
        end
`else
        // Scan from farthest to nearest so the first port after ptr is written last.
        for (int k = NPORTS; k >= 1; k--) begin
            int j;
            j   = (int'(ptr) + k) % NPORTS;
            rot = req >> j;
            if (rot[0]) begin
                gnt = ONE << j;
                idx = IDX_W'(j);
            end
        end
`endif
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares the single SdramCtrl request port among NPORTS requesters with one
//   outstanding transaction at a time. Grant is held until the write ack or the
//   read data strobe, then re-arbitrated after one IDLE cycle.
//   Ports:
//     clk, reset_l                 clock, asynchronous active-low reset
//     m_req/m_addr/m_rh_wl/m_data_w  per-port command, held until m_ack
//     m_ack                        one-cycle accept pulse to the owner
//     m_data_r / m_data_r_en       broadcast read data / per-port strobe
//     grant                        one-hot current owner, 0 when idle
//     sdram_*                      SdramCtrl request interface
//   Configuration macro SDRAM_ARB_FIXED_PRIO_EN: fixed priority (port 0 highest)
//   instead of round-robin; the rotation pointer then stays at its reset value.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic [NPORTS-1:0]        m_req,
    output logic [NPORTS-1:0]        m_ack,
    input  logic [NPORTS*ADDR_W-1:0] m_addr,
    input  logic [NPORTS-1:0]        m_rh_wl,
    input  logic [NPORTS*DATA_W-1:0] m_data_w,
    output logic [DATA_W-1:0]        m_data_r,
    output logic [NPORTS-1:0]        m_data_r_en,
    output logic [NPORTS-1:0]        grant,
    output logic                     sdram_req,
    input  logic                     sdram_ack,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic                     sdram_rh_wl,
    output logic [DATA_W-1:0]        sdram_data_w,
    input  logic [DATA_W-1:0]        sdram_data_r,
    input  logic                     sdram_data_r_en
);

    arb_state_t             state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       owner;
    logic [NPORTS-1:0]      pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic [MAX_PORTS-1:0]   grant_ext;
    logic [ADDR_W-1:0]      sel_addr;
    logic                   sel_rh_wl;
    logic [DATA_W-1:0]      sel_data_w;

    sdram_arb_pick #(.NPORTS(NPORTS)) u_pick (
        .req (m_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    // Winner's command, selected by the one-hot pick so no index arithmetic is needed.
    always_comb begin
        sel_addr   = '0;
        sel_rh_wl  = 1'b0;
        sel_data_w = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (pick_gnt[i]) begin
                sel_addr   = m_addr[i*ADDR_W +: ADDR_W];
                sel_rh_wl  = m_rh_wl[i];
                sel_data_w = m_data_w[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        grant_ext             = '0;
        grant_ext[NPORTS-1:0] = grant;
        owner                 = onehot_to_idx(grant_ext);
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state        <= IDLE;
            grant        <= '0;
            ptr          <= IDX_W'(NPORTS - 1);
            sdram_addr   <= '0;
            sdram_rh_wl  <= 1'b0;
            sdram_data_w <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_req) begin
                        grant        <= pick_gnt;
                        sdram_addr   <= sel_addr;
                        sdram_rh_wl  <= sel_rh_wl;
                        sdram_data_w <= sel_data_w;
                        state        <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        // A read whose data arrives with the ack completes at once.
                        if (!sdram_rh_wl || sdram_data_r_en) begin
                            state <= IDLE;
                            grant <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                            ptr   <= owner;
`endif
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (sdram_data_r_en) begin
                        state <= IDLE;
                        grant <= '0;
`ifndef SDRAM_ARB_FIXED_PRIO_EN
                        ptr   <= owner;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Request is a pure decode of the state register; it drops the cycle after ack.
    assign sdram_req   = (state == WAIT_ACK);
    assign m_ack       = (state == WAIT_ACK && sdram_ack) ? grant : '0;
    assign m_data_r_en = (state != IDLE && sdram_data_r_en) ? grant : '0;
    assign m_data_r    = sdram_data_r;

endmodule
